keypad_bcd_entry: RTL and testbench
===================================

Name: keypad_bcd_entry

Overview:
- Input-side counterpart of the 4-digit display multiplexer: scans a 4x4 matrix keypad, debounces key presses, and assembles a signed 3-digit BCD operand for the multiplier datapath.
- Drives the keypad columns active-low one at a time and reads the four active-low rows.
- Emits one registered pulse per debounced key press.
- The multiplier and display path consume the operand and its sign (12-bit BCD plus sign bit).

Parameters:
SCAN_TICKS, 10000, clk cycles each column is driven before the rows are sampled and the scan advances.
DEBOUNCE_CYCLES, 50000, clk cycles a row pattern must stay stable for a press or release to be accepted.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
rows  input  4  raw keypad rows, active-low, asynchronous to clk.
cols  output  4  keypad column drive, active-low, one-cold.
key_valid  output  1  one-cycle pulse when a debounced key is accepted.
key_code  output  4  code of the last accepted key; held between pulses.
bcd_operand  output  12  operand as {hundreds, tens, units} BCD.
sign  output  1  operand sign; 1 = negative.
digit_count  output  2  digits entered so far, 0 to 3.
operand_ready  output  1  one-cycle pulse when the operand is committed with '#'.

Behaviour:
- Everything is synchronous to clk. Reset is synchronous, active-high and overrides all other activity, including mid-debounce or mid-release.
- Reset values: cols = 4'b1110, key_valid = 0, key_code = 0, bcd_operand = 0, sign = 0, digit_count = 0, operand_ready = 0. The FSM goes to SCAN with col_sel = 0 and all counters = 0.
- rows passes through a 2-FF synchronizer (reset to 4'hF). All logic uses only the synchronized value rs.
- Key map (row r, column c → key_code):
  - r0: 1, 2, 3, A=10
  - r1: 4, 5, 6, B=11
  - r2: 7, 8, 9, C=12
  - r3: *=14, 0, #=15, D=13
- cols = ~(4'b0001 << col_sel).
- FSM states:
  - SCAN: tick counter runs 0 to SCAN_TICKS-1. On the last tick:
    - if rs == 4'hF, col_sel increments (wraps 3→0) and the tick counter clears;
    - otherwise the row pattern is captured and col_sel is held. The lowest-indexed low row wins when several are low. The FSM goes to DEBOUNCE.
  - DEBOUNCE: counts DEBOUNCE_CYCLES cycles.
    - If rs differs from the captured pattern on any cycle, go to SCAN and advance col_sel; nothing is emitted.
    - On completion, the next cycle key_valid = 1 and key_code = map(row, col_sel), then go to RELEASE.
  - RELEASE: col_sel is held. rs must equal 4'hF for DEBOUNCE_CYCLES consecutive cycles; any low row restarts the count. On completion go to SCAN with col_sel+1.
  - Consequences: one pulse per press regardless of hold time, and no auto-repeat.
- Operand update happens the cycle after key_valid:
  - Digit 0-9:
    - if an operand was committed since the last edit, clear bcd_operand/sign/digit_count first, then load the digit as units, count = 1;
    - else if digit_count < 3, bcd_operand <= {bcd_operand[7:0], digit} and digit_count++;
    - else the digit is ignored (4th digit dropped; operand unchanged).
  - '*': toggles sign. This is allowed at any count and clears the committed flag without clearing digits.
  - 'C': bcd_operand = 0, sign = 0, digit_count = 0, committed flag cleared.
  - '#': operand_ready pulses for 1 cycle and the committed flag is set. bcd_operand, sign and digit_count hold. '#' with digit_count = 0 still pulses, with operand 0.
  - A, B, D: key_valid only; the operand is unchanged.
- Latency from a rows change to key_valid is 2 (sync) + remaining scan ticks + DEBOUNCE_CYCLES + 1 cycles.

Test Plan (SCAN_TICKS=4, DEBOUNCE_CYCLES=8):
1. Reset is asserted mid-DEBOUNCE with rows held at 4'b1101 → next cycle: cols = 4'b1110, all outputs are 0, and no key_valid appears until a new full debounce completes.
2. Press '5' (rows = 4'b1101 while cols = 4'b1101), held for 100 cycles → exactly one key_valid with key_code = 5; bcd_operand = 12'h005, digit_count = 1; a second press only follows release plus 8 clean cycles.
3. A glitch of rows = 4'b1110 for 3 cycles during column 0 → no key_valid, and the scan resumes with column 1.
4. Key sequence 1, 2, 3, 4 → bcd_operand = 12'h123, digit_count = 3; '4' is ignored.
5. Sequence 7, '*', '#' → sign = 1, bcd_operand = 12'h007, one operand_ready pulse. A following '9' gives bcd_operand = 12'h009, sign = 0, count = 1.
6. Sequence 4, 2, 'C' → bcd_operand = 0, sign = 0, digit_count = 0. Pressing row 0 and row 2 together in column 0 gives key_code = 1 (lowest row wins).

Source files
------------

// File: rtl/keypad_bcd_entry.sv
// 4x4 matrix keypad scanner with debounce, feeding a signed 3-digit BCD operand
// (12-bit BCD plus sign) to the multiplier datapath.
module keypad_bcd_entry #(
   parameter int SCAN_TICKS      = 10000,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  rows,
   output logic [3:0]  cols,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic [11:0] bcd_operand,
   output logic        sign,
   output logic [1:0]  digit_count,
   output logic        operand_ready
);

   localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

   localparam logic [3:0] KEY_C    = 4'd12;
   localparam logic [3:0] KEY_STAR = 4'd14;
   localparam logic [3:0] KEY_HASH = 4'd15;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_RELEASE  = 2'd2
   } state_t;

   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'b00_00: code = 4'd1;
         4'b00_01: code = 4'd2;
         4'b00_10: code = 4'd3;
         4'b00_11: code = 4'd10;
         4'b01_00: code = 4'd4;
         4'b01_01: code = 4'd5;
         4'b01_10: code = 4'd6;
         4'b01_11: code = 4'd11;
         4'b10_00: code = 4'd7;
         4'b10_01: code = 4'd8;
         4'b10_10: code = 4'd9;
         4'b10_11: code = 4'd12;
         4'b11_00: code = 4'd14;
         4'b11_01: code = 4'd0;
         4'b11_10: code = 4'd15;
         4'b11_11: code = 4'd13;
         default:  code = 4'd0;
      endcase
      return code;
   endfunction

   // Lowest-indexed low row wins when several rows are pressed together.
   function automatic logic [1:0] lowest_row(input logic [3:0] r);
      logic [1:0] idx;
      if (r[0] == 1'b0) begin
         idx = 2'd0;
      end else if (r[1] == 1'b0) begin
         idx = 2'd1;
      end else if (r[2] == 1'b0) begin
         idx = 2'd2;
      end else begin
         idx = 2'd3;
      end
      return idx;
   endfunction

   logic [3:0]    sync_r;
   logic [3:0]    rs_r;
   state_t        state_r;
   state_t        state_nxt_s;
   logic [TW-1:0] tick_r;
   logic [DW-1:0] cnt_r;
   logic [1:0]    col_sel_r;
   logic [1:0]    col_nxt_s;
   logic [3:0]    cap_r;
   logic [1:0]    row_r;
   logic [3:0]    cols_r;
   logic          key_valid_r;
   logic [3:0]    key_code_r;
   logic [11:0]   bcd_r;
   logic          sign_r;
   logic [1:0]    count_r;
   logic          ready_r;
   logic          committed_r;

   logic tick_last_s;
   logic cnt_last_s;
   logic tick_inc_s;
   logic tick_clr_s;
   logic cnt_inc_s;
   logic cnt_clr_s;
   logic col_adv_s;
   logic capture_s;
   logic fire_s;

   assign tick_last_s = (tick_r == TICK_LAST);
   assign cnt_last_s  = (cnt_r == DEB_LAST);
   assign col_nxt_s   = col_adv_s ? (col_sel_r + 2'd1) : col_sel_r;

   // Two-flop synchronizer for the asynchronous rows.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_r <= 4'hF;
         rs_r   <= 4'hF;
      end else begin
         sync_r <= rows;
         rs_r   <= sync_r;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_SCAN;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_SCAN: begin
            if (tick_last_s && (rs_r != 4'hF)) begin
               state_nxt_s = ST_DEBOUNCE;
            end else begin
               state_nxt_s = ST_SCAN;
            end
         end
         ST_DEBOUNCE: begin
            if (rs_r != cap_r) begin
               state_nxt_s = ST_SCAN;
            end else if (cnt_last_s) begin
               state_nxt_s = ST_RELEASE;
            end else begin
               state_nxt_s = ST_DEBOUNCE;
            end
         end
         ST_RELEASE: begin
            if ((rs_r == 4'hF) && cnt_last_s) begin
               state_nxt_s = ST_SCAN;
            end else begin
               state_nxt_s = ST_RELEASE;
            end
         end
         default: state_nxt_s = ST_SCAN;
      endcase
   end

   // FSM output strobes steering counters, column select and key capture.
   always_comb begin
      tick_inc_s = 1'b0;
      tick_clr_s = 1'b0;
      cnt_inc_s  = 1'b0;
      cnt_clr_s  = 1'b0;
      col_adv_s  = 1'b0;
      capture_s  = 1'b0;
      fire_s     = 1'b0;
      case (state_r)
         ST_SCAN: begin
            cnt_clr_s = 1'b1;
            if (tick_last_s) begin
               tick_clr_s = 1'b1;
               if (rs_r == 4'hF) begin
                  col_adv_s = 1'b1;
               end else begin
                  capture_s = 1'b1;
               end
            end else begin
               tick_inc_s = 1'b1;
            end
         end
         ST_DEBOUNCE: begin
            if (rs_r != cap_r) begin
               col_adv_s = 1'b1;
               cnt_clr_s = 1'b1;
            end else if (cnt_last_s) begin
               fire_s    = 1'b1;
               cnt_clr_s = 1'b1;
            end else begin
               cnt_inc_s = 1'b1;
            end
         end
         ST_RELEASE: begin
            if (rs_r != 4'hF) begin
               cnt_clr_s = 1'b1;
            end else if (cnt_last_s) begin
               cnt_clr_s = 1'b1;
               col_adv_s = 1'b1;
            end else begin
               cnt_inc_s = 1'b1;
            end
         end
         default: begin
            tick_clr_s = 1'b1;
            cnt_clr_s  = 1'b1;
         end
      endcase
   end

   // Scan/debounce counters, column drive and row capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         tick_r    <= '0;
         cnt_r     <= '0;
         col_sel_r <= 2'd0;
         cols_r    <= 4'b1110;
         cap_r     <= 4'hF;
         row_r     <= 2'd0;
      end else begin
         if (tick_clr_s) begin
            tick_r <= '0;
         end else if (tick_inc_s) begin
            tick_r <= tick_r + TW'(1);
         end else begin
            tick_r <= tick_r;
         end
         if (cnt_clr_s) begin
            cnt_r <= '0;
         end else if (cnt_inc_s) begin
            cnt_r <= cnt_r + DW'(1);
         end else begin
            cnt_r <= cnt_r;
         end
         col_sel_r <= col_nxt_s;
         cols_r    <= ~(4'b0001 << col_nxt_s);
         if (capture_s) begin
            cap_r <= rs_r;
            row_r <= lowest_row(rs_r);
         end else begin
            cap_r <= cap_r;
            row_r <= row_r;
         end
      end
   end

   // Key pulse and held key code.
   always_ff @(posedge clk) begin
      if (reset) begin
         key_valid_r <= 1'b0;
         key_code_r  <= 4'd0;
      end else begin
         key_valid_r <= fire_s;
         if (fire_s) begin
            key_code_r <= key_map(row_r, col_sel_r);
         end else begin
            key_code_r <= key_code_r;
         end
      end
   end

   // Operand assembly, one cycle after each accepted key.
   always_ff @(posedge clk) begin
      if (reset) begin
         bcd_r       <= 12'h000;
         sign_r      <= 1'b0;
         count_r     <= 2'd0;
         ready_r     <= 1'b0;
         committed_r <= 1'b0;
      end else begin
         ready_r <= 1'b0;
         if (key_valid_r) begin
            if (key_code_r <= 4'd9) begin
               if (committed_r) begin
                  bcd_r       <= {8'h00, key_code_r};
                  sign_r      <= 1'b0;
                  count_r     <= 2'd1;
                  committed_r <= 1'b0;
               end else if (count_r < 2'd3) begin
                  bcd_r   <= {bcd_r[7:0], key_code_r};
                  count_r <= count_r + 2'd1;
               end else begin
                  bcd_r <= bcd_r;
               end
            end else begin
               case (key_code_r)
                  KEY_STAR: begin
                     sign_r      <= ~sign_r;
                     committed_r <= 1'b0;
                  end
                  KEY_C: begin
                     bcd_r       <= 12'h000;
                     sign_r      <= 1'b0;
                     count_r     <= 2'd0;
                     committed_r <= 1'b0;
                  end
                  KEY_HASH: begin
                     ready_r     <= 1'b1;
                     committed_r <= 1'b1;
                  end
                  default: bcd_r <= bcd_r;
               endcase
            end
         end else begin
            bcd_r <= bcd_r;
         end
      end
   end

   assign cols          = cols_r;
   assign key_valid     = key_valid_r;
   assign key_code      = key_code_r;
   assign bcd_operand   = bcd_r;
   assign sign          = sign_r;
   assign digit_count   = count_r;
   assign operand_ready = ready_r;

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Directed bench for keypad_bcd_entry: a keypad model answers the column drive,
// and each scenario task checks pulses and operand state against hand-derived values.
module tb_keypad_bcd_entry;

   logic        clk;
   logic        reset;
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [11:0] bcd_operand;
   logic        sign;
   logic [1:0]  digit_count;
   logic        operand_ready;

   logic [15:0] pressed;
   logic        force_en;
   logic [3:0]  force_val;
   logic [3:0]  rows_kp;

   int checks;
   int errors;
   int kv_cnt;
   int rdy_cnt;

   keypad_bcd_entry #(.SCAN_TICKS(4), .DEBOUNCE_CYCLES(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .rows          (rows),
      .cols          (cols),
      .key_valid     (key_valid),
      .key_code      (key_code),
      .bcd_operand   (bcd_operand),
      .sign          (sign),
      .digit_count   (digit_count),
      .operand_ready (operand_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Key (r,c) at bit r*4+c pulls row r low while column c is driven low.
   always_comb begin
      rows_kp = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4+c] && (cols[c] == 1'b0)) rows_kp[r] = 1'b0;
         end
      end
   end
   assign rows = force_en ? force_val : rows_kp;

   always @(negedge clk) begin
      if (key_valid === 1'b1) kv_cnt++;
      if (operand_ready === 1'b1) rdy_cnt++;
   end

   task automatic do_reset();
      pressed  = 16'h0000;
      force_en = 1'b0;
      reset    = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic press(input logic [15:0] mask, input int hold,
                        output logic [3:0] code, output int pulses);
      int start;
      start   = kv_cnt;
      code    = 4'bxxxx;
      pressed = mask;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (key_valid === 1'b1) begin
            code = key_code;
            break;
         end
      end
      repeat (hold) @(negedge clk);
      pressed = 16'h0000;
      repeat (20) @(negedge clk);
      pulses = kv_cnt - start;
   endtask

   task automatic test_reset();
      logic [3:0] code;
      int pulses;
      int start;
      int edges;
      do_reset();
      checks++; if (cols !== 4'b1110) begin errors++; $display("FAIL rst_cols got %b exp %b", cols, 4'b1110); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rst_key_valid got %b exp 0", key_valid); end
      checks++; if (bcd_operand !== 12'h000) begin errors++; $display("FAIL rst_bcd got %h exp 000", bcd_operand); end
      checks++; if (digit_count !== 2'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", digit_count); end
      // Build non-zero state: '5' then '*'.
      press(16'h0020, 5, code, pulses);
      press(16'h1000, 5, code, pulses);
      checks++; if ({sign, bcd_operand} !== {1'b1, 12'h005}) begin errors++; $display("FAIL pre_state got %b/%h exp 1/005", sign, bcd_operand); end
      // Hold rows low to enter debounce, then reset in the middle of it.
      start     = kv_cnt;
      force_en  = 1'b1;
      force_val = 4'b1101;
      repeat (8) @(negedge clk);
      checks++; if (kv_cnt !== start) begin errors++; $display("FAIL mid_deb_pulse got %0d exp %0d", kv_cnt, start); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (cols !== 4'b1110) begin errors++; $display("FAIL mid_rst_cols got %b exp %b", cols, 4'b1110); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_kv got %b exp 0", key_valid); end
      checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL mid_rst_code got %0d exp 0", key_code); end
      checks++; if (bcd_operand !== 12'h000) begin errors++; $display("FAIL mid_rst_bcd got %h exp 000", bcd_operand); end
      checks++; if (sign !== 1'b0) begin errors++; $display("FAIL mid_rst_sign got %b exp 0", sign); end
      checks++; if (digit_count !== 2'd0) begin errors++; $display("FAIL mid_rst_count got %0d exp 0", digit_count); end
      checks++; if (operand_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", operand_ready); end
      // 2 sync + 2 remaining ticks + 8 debounce: key_valid visible after edge 12.
      edges = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         edges++;
         if (key_valid === 1'b1) break;
      end
      checks++; if (edges !== 12) begin errors++; $display("FAIL rst_latency got %0d exp 12", edges); end
      checks++; if (key_code !== 4'd4) begin errors++; $display("FAIL rst_code got %0d exp 4", key_code); end
      force_en = 1'b0;
      repeat (20) @(negedge clk);
      checks++; if (bcd_operand !== 12'h004) begin errors++; $display("FAIL rst_bcd_after got %h exp 004", bcd_operand); end
   endtask

   task automatic test_press();
      logic [3:0] code;
      int pulses;
      int start;
      do_reset();
      press(16'h0020, 100, code, pulses);
      checks++; if (code !== 4'd5) begin errors++; $display("FAIL press_code got %0d exp 5", code); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL press_pulses got %0d exp 1", pulses); end
      checks++; if (bcd_operand !== 12'h005) begin errors++; $display("FAIL press_bcd got %h exp 005", bcd_operand); end
      checks++; if (digit_count !== 2'd1) begin errors++; $display("FAIL press_count got %0d exp 1", digit_count); end
      // A short release inside the release window must not produce a second pulse.
      start   = kv_cnt;
      pressed = 16'h0020;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (key_valid === 1'b1) break;
      end
      repeat (10) @(negedge clk);
      pressed = 16'h0000;
      repeat (3) @(negedge clk);
      pressed = 16'h0020;
      repeat (30) @(negedge clk);
      pressed = 16'h0000;
      repeat (20) @(negedge clk);
      checks++; if ((kv_cnt - start) !== 1) begin errors++; $display("FAIL bounce_pulses got %0d exp 1", kv_cnt - start); end
      checks++; if (bcd_operand !== 12'h055) begin errors++; $display("FAIL bounce_bcd got %h exp 055", bcd_operand); end
      press(16'h0020, 5, code, pulses);
      checks++; if (pulses !== 1) begin errors++; $display("FAIL second_pulses got %0d exp 1", pulses); end
      checks++; if ({digit_count, bcd_operand} !== {2'd3, 12'h555}) begin errors++; $display("FAIL second_bcd got %0d/%h exp 3/555", digit_count, bcd_operand); end
   endtask

   task automatic test_glitch();
      int start;
      int edges;
      do_reset();
      start     = kv_cnt;
      force_en  = 1'b1;
      force_val = 4'b1110;
      repeat (3) @(negedge clk);
      force_en = 1'b0;
      edges    = 3;
      while ((cols === 4'b1110) && (edges < 40)) begin
         @(negedge clk);
         edges++;
      end
      checks++; if (cols !== 4'b1101) begin errors++; $display("FAIL glitch_col got %b exp %b", cols, 4'b1101); end
      checks++; if (edges !== 6) begin errors++; $display("FAIL glitch_abort_edge got %0d exp 6", edges); end
      repeat (60) @(negedge clk);
      checks++; if (kv_cnt !== start) begin errors++; $display("FAIL glitch_pulses got %0d exp %0d", kv_cnt - start, 0); end
   endtask

   task automatic test_digits();
      logic [3:0] code;
      int pulses;
      do_reset();
      press(16'h0001, 5, code, pulses);
      press(16'h0002, 5, code, pulses);
      press(16'h0004, 5, code, pulses);
      checks++; if ({digit_count, bcd_operand} !== {2'd3, 12'h123}) begin errors++; $display("FAIL digits_123 got %0d/%h exp 3/123", digit_count, bcd_operand); end
      press(16'h0010, 5, code, pulses);
      checks++; if (code !== 4'd4) begin errors++; $display("FAIL digits_code4 got %0d exp 4", code); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL digits_pulses got %0d exp 1", pulses); end
      checks++; if ({digit_count, bcd_operand} !== {2'd3, 12'h123}) begin errors++; $display("FAIL digits_4th got %0d/%h exp 3/123", digit_count, bcd_operand); end
   endtask

   task automatic test_sign_commit();
      logic [3:0] code;
      int pulses;
      int start;
      do_reset();
      start = rdy_cnt;
      press(16'h0100, 5, code, pulses);
      press(16'h1000, 5, code, pulses);
      checks++; if (code !== 4'd14) begin errors++; $display("FAIL star_code got %0d exp 14", code); end
      checks++; if (rdy_cnt !== start) begin errors++; $display("FAIL star_ready got %0d exp 0", rdy_cnt - start); end
      press(16'h4000, 5, code, pulses);
      checks++; if (code !== 4'd15) begin errors++; $display("FAIL hash_code got %0d exp 15", code); end
      checks++; if ((rdy_cnt - start) !== 1) begin errors++; $display("FAIL hash_ready got %0d exp 1", rdy_cnt - start); end
      checks++; if ({sign, digit_count, bcd_operand} !== {1'b1, 2'd1, 12'h007}) begin errors++; $display("FAIL hash_hold got %b/%0d/%h exp 1/1/007", sign, digit_count, bcd_operand); end
      press(16'h0400, 5, code, pulses);
      checks++; if ({sign, digit_count, bcd_operand} !== {1'b0, 2'd1, 12'h009}) begin errors++; $display("FAIL after_commit got %b/%0d/%h exp 0/1/009", sign, digit_count, bcd_operand); end
   endtask

   task automatic test_clear_multi();
      logic [3:0] code;
      int pulses;
      int start;
      do_reset();
      press(16'h0010, 5, code, pulses);
      press(16'h0002, 5, code, pulses);
      checks++; if (bcd_operand !== 12'h042) begin errors++; $display("FAIL clr_pre got %h exp 042", bcd_operand); end
      press(16'h0800, 5, code, pulses);
      checks++; if ({sign, digit_count, bcd_operand} !== {1'b0, 2'd0, 12'h000}) begin errors++; $display("FAIL clr_state got %b/%0d/%h exp 0/0/000", sign, digit_count, bcd_operand); end
      start = rdy_cnt;
      press(16'h4000, 5, code, pulses);
      checks++; if ((rdy_cnt - start) !== 1) begin errors++; $display("FAIL empty_hash_ready got %0d exp 1", rdy_cnt - start); end
      checks++; if (bcd_operand !== 12'h000) begin errors++; $display("FAIL empty_hash_bcd got %h exp 000", bcd_operand); end
      press(16'h0101, 5, code, pulses);
      checks++; if (code !== 4'd1) begin errors++; $display("FAIL multi_code got %0d exp 1", code); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL multi_pulses got %0d exp 1", pulses); end
      checks++; if ({digit_count, bcd_operand} !== {2'd1, 12'h001}) begin errors++; $display("FAIL multi_bcd got %0d/%h exp 1/001", digit_count, bcd_operand); end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      kv_cnt    = 0;
      rdy_cnt   = 0;
      pressed   = 16'h0000;
      force_en  = 1'b0;
      force_val = 4'hF;
      reset     = 1'b1;
      test_reset();
      test_press();
      test_glitch();
      test_digits();
      test_sign_commit();
      test_clear_multi();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
